addsub_ascii_seq: RTL and testbench

Parametrised, nibble-serial add/subtract unit. It replaces the single-nibble combinational adder and its fixed start-delay pulse with a sequential datapath that computes WIDTH-bit sums and differences four bits per cycle. It renders the result as an ASCII hex string and streams the string over a valid/ready handshake to the UART transmit path. Negative differences are shown as a sign plus magnitude.

---
 rtl/addsub_ascii_seq_pkg.sv | 11 +
 rtl/addsub_ascii_seq_nibble_add.sv | 16 +
 rtl/addsub_ascii_seq.sv | 136 +++++++++++++
 tb/tb_addsub_ascii_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_ascii_seq_pkg.sv
// addsub_pkg: shared FSM state type, ASCII constants and nibble-to-hex-character helper
package addsub_pkg;
  typedef enum logic [2:0] {IDLE, CALC, FIXUP, EMIT, DONE} state_t;
  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_A = 8'h41;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_ONE = 8'h31;
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return n < 4'd10 ? ASC_0 + 8'(n) : ASC_A + 8'(n) - 8'd10;
  endfunction
endpackage

// File: rtl/addsub_ascii_seq_nibble_add.sv
// nibble_add: 4-bit ripple adder slice (a, b, cin -> s, cout) built from four full-adder cells
module nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

// File: rtl/addsub_ascii_seq.sv
// addsub_ascii_seq: nibble-serial add/sub of Gl_r1/Gl_r2 on Gl_adder_start, result streamed as ASCII hex on L3_data/L3_valid/Gl_ready, with L3_busy, L3_done, L3_led status
module addsub_ascii_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Gl_rst_n,
  input  logic             Gl_adder_start,
  input  logic             Gl_subtract,
  input  logic [WIDTH-1:0] Gl_r1,
  input  logic [WIDTH-1:0] Gl_r2,
  input  logic             Gl_ready,
  output logic [7:0]       L3_data,
  output logic             L3_valid,
  output logic             L3_busy,
  output logic             L3_done,
  output logic [7:0]       L3_led
);
  localparam int N = WIDTH / 4;
  localparam int CW = $clog2(N + 2);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_nx;
  logic sub_q, sub_d, c_q, c_d, neg_q, neg_d, flag_q, flag_d, valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d, led_q, led_d, chr;
  logic [3:0] sum;
  logic cout;
  int di, sh;
  function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x);
    return (x >> 4) | (x << (WIDTH - 4));
  endfunction
  nibble_add u_add (
    .a   (a_q[3:0]),
    .b   (b_q[3:0] ^ {4{sub_q}}),
    .cin (c_q),
    .s   (sum),
    .cout(cout)
  );
  assign res_nx = (res_q >> 4) | (WIDTH'(sum) << (WIDTH - 4));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    sub_d = sub_q;
    c_d = c_q;
    neg_d = neg_q;
    flag_d = flag_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    data_d = data_q;
    led_d = led_q;
    di = int'(cnt_q) - int'(flag_q);
    sh = (di >= 0 && di < N) ? 4 * (N - 1 - di) : 0;
    chr = (flag_q && cnt_q == '0) ? (neg_q ? ASC_MINUS : ASC_ONE) : hex2ascii(4'(res_q >> sh));
    case (state_q)
      IDLE: if (Gl_adder_start) begin
        a_d = Gl_r1;
        b_d = Gl_r2;
        sub_d = Gl_subtract;
        c_d = Gl_subtract;
        cnt_d = '0;
        neg_d = 1'b0;
        flag_d = 1'b0;
        state_d = CALC;
      end
      CALC, FIXUP: begin
        a_d = rot(a_q);
        b_d = rot(b_q);
        res_d = res_nx;
        c_d = cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cnt_d = '0;
          if (state_q == CALC && sub_q && !cout) begin
            a_d = rot(b_q);
            b_d = rot(a_q);
            c_d = 1'b1;
            neg_d = 1'b1;
            state_d = FIXUP;
          end else begin
            flag_d = (state_q == FIXUP) || (!sub_q && cout);
            led_d = {flag_d, 7'(res_nx)};
            state_d = EMIT;
          end
        end
      end
      EMIT: if (!valid_q || Gl_ready) begin
        if (int'(cnt_q) < N + int'(flag_q)) begin
          data_d = chr;
          valid_d = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end else begin
          valid_d = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Gl_rst_n) begin
    if (!Gl_rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      sub_q <= 1'b0;
      c_q <= 1'b0;
      neg_q <= 1'b0;
      flag_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      data_q <= '0;
      led_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      sub_q <= sub_d;
      c_q <= c_d;
      neg_q <= neg_d;
      flag_q <= flag_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      led_q <= led_d;
    end
  end
  assign L3_data = data_q;
  assign L3_valid = valid_q;
  assign L3_busy = state_q != IDLE;
  assign L3_done = state_q == DONE;
  assign L3_led = led_q;
endmodule

// File: tb/tb_addsub_ascii_seq.sv
// tb_addsub_ascii_seq: directed bench with a transaction-level model for WIDTH=8 and WIDTH=16 instances
module tb_addsub_ascii_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic st[2], sb[2], rdy[2];
  logic [15:0] r1[2], r2[2];
  logic [7:0] data[2], led[2];
  logic valid[2], busy[2], done[2];
  int errors = 0, checks = 0;
  int ph[2], wcnt[2], wload[2], lat[2], mlat[2], mlen[2], midx[2];
  logic [7:0] mq[2][9];
  logic [7:0] m_data[2], m_led[2], led_pend[2];
  logic m_valid[2], m_done[2], m_busy[2];
  logic [7:0] acc[$];
  always #5 clk = ~clk;
  addsub_ascii_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .Gl_rst_n(rst_n), .Gl_adder_start(st[0]), .Gl_subtract(sb[0]),
    .Gl_r1(r1[0][7:0]), .Gl_r2(r2[0][7:0]), .Gl_ready(rdy[0]),
    .L3_data(data[0]), .L3_valid(valid[0]), .L3_busy(busy[0]), .L3_done(done[0]), .L3_led(led[0])
  );
  addsub_ascii_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .Gl_rst_n(rst_n), .Gl_adder_start(st[1]), .Gl_subtract(sb[1]),
    .Gl_r1(r1[1]), .Gl_r2(r2[1]), .Gl_ready(rdy[1]),
    .L3_data(data[1]), .L3_valid(valid[1]), .L3_busy(busy[1]), .L3_done(done[1]), .L3_led(led[1])
  );
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask
  // Whole-result model: plain arithmetic gives the character string, led and latency.
  task automatic model_start(input int k);
    int n, w, nib;
    longint unsigned a, b, s, mag, mask;
    bit pre;
    logic [7:0] pc;
    w = k ? 16 : 8;
    n = w / 4;
    mask = (64'd1 << w) - 1;
    a = r1[k] & mask;
    b = r2[k] & mask;
    pc = 8'h31;
    if (!sb[k]) begin
      s = a + b;
      pre = s > mask;
      mag = s & mask;
      wload[k] = n;
    end else if (a >= b) begin
      pre = 0;
      mag = a - b;
      wload[k] = n;
    end else begin
      pre = 1;
      mag = b - a;
      pc = 8'h2D;
      wload[k] = 2 * n;
    end
    mlen[k] = 0;
    midx[k] = 0;
    if (pre) begin
      mq[k][0] = pc;
      mlen[k] = 1;
    end
    for (int i = n - 1; i >= 0; i--) begin
      nib = int'((mag >> (4 * i)) & 15);
      mq[k][mlen[k]] = 8'(nib < 10 ? 48 + nib : 55 + nib);
      mlen[k]++;
    end
    led_pend[k] = {pre, mag[6:0]};
  endtask
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k] = 0;
        m_valid[k] = 0;
        m_done[k] = 0;
        m_busy[k] = 0;
        m_led[k] = 8'h00;
        m_data[k] = 8'h00;
      end else begin
        if (valid[k] && rdy[k]) acc.push_back(data[k]);
        case (ph[k])
          0: if (st[k]) begin
            model_start(k);
            m_busy[k] = 1;
            wcnt[k] = wload[k];
            lat[k] = 0;
            ph[k] = 1;
          end
          1: begin
            wcnt[k]--;
            lat[k]++;
            if (wcnt[k] == 0) begin
              m_led[k] = led_pend[k];
              ph[k] = 2;
            end
          end
          2: begin
            lat[k]++;
            if (!m_valid[k] || rdy[k]) begin
              if (midx[k] < mlen[k]) begin
                if (midx[k] == 0) mlat[k] = lat[k];
                m_data[k] = mq[k][midx[k]];
                midx[k]++;
                m_valid[k] = 1;
              end else begin
                m_valid[k] = 0;
                m_done[k] = 1;
                ph[k] = 3;
              end
            end
          end
          default: begin
            m_done[k] = 0;
            m_busy[k] = 0;
            ph[k] = 0;
          end
        endcase
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("valid", k, 32'(valid[k]), 32'(m_valid[k]));
      chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
      chk("done", k, 32'(done[k]), 32'(m_done[k]));
      chk("led", k, 32'(led[k]), 32'(m_led[k]));
      if (m_valid[k]) chk("data", k, 32'(data[k]), 32'(m_data[k]));
    end
  end
  task automatic op(input int k, input bit s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    acc.delete();
    st[k] = 1;
    sb[k] = s;
    r1[k] = a;
    r2[k] = b;
    @(negedge clk);
    st[k] = 0;
  endtask
  task automatic wait_done(input int k);
    int n = 0;
    while (!done[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", k, 32'(done[k]), 32'd1);
  endtask
  task automatic wait_valid(input int k);
    int n = 0;
    while (!valid[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", k, 32'(valid[k]), 32'd1);
  endtask
  task automatic chk_str(input int k, input string s);
    chk("str_len", k, 32'(acc.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < acc.size(); i++) chk("str_char", k, 32'(acc[i]), 32'(s[i]));
  endtask
  initial begin
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      st[k] = 0; sb[k] = 0; rdy[k] = 1; r1[k] = '0; r2[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_data", 0, 32'(data[0]), 32'h00);
    chk("rst_busy", 0, 32'(busy[0]), 32'h0);
    rst_n = 1;
    op(0, 0, 16'h3A, 16'h05);
    wait_done(0);
    chk_str(0, "3F");
    chk("led_lit", 0, 32'(led[0]), 32'h3F);
    chk("lat_lit", 0, 32'(mlat[0]), 32'd3);
    op(0, 0, 16'hFF, 16'h01);
    wait_done(0);
    chk_str(0, "100");
    chk("led_lit", 0, 32'(led[0]), 32'h80);
    op(0, 1, 16'h05, 16'h09);
    wait_done(0);
    chk_str(0, "-04");
    chk("led_lit", 0, 32'(led[0]), 32'h84);
    chk("lat_lit", 0, 32'(mlat[0]), 32'd5);
    op(0, 1, 16'h42, 16'h42);
    wait_valid(0);
    st[0] = 1; r1[0] = 16'h77; r2[0] = 16'h11;
    @(negedge clk);
    st[0] = 0;
    wait_done(0);
    st[0] = 1;
    @(negedge clk);
    st[0] = 0;
    chk("start_in_done", 0, 32'(busy[0]), 32'h0);
    chk_str(0, "00");
    chk("led_lit", 0, 32'(led[0]), 32'h00);
    rdy[0] = 0;
    op(0, 0, 16'h3A, 16'h05);
    wait_valid(0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", 0, 32'(data[0]), 32'h33);
      chk("bp_valid", 0, 32'(valid[0]), 32'h1);
    end
    rdy[0] = 1;
    wait_done(0);
    chk_str(0, "3F");
    op(1, 0, 16'h1234, 16'hEDCC);
    wait_done(1);
    chk_str(1, "10000");
    chk("led_lit", 1, 32'(led[1]), 32'h80);
    op(1, 0, 16'h0001, 16'h0002);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("arst_data", 1, 32'(data[1]), 32'h00);
    chk("arst_valid", 1, 32'(valid[1]), 32'h0);
    chk("arst_busy", 1, 32'(busy[1]), 32'h0);
    chk("arst_done", 1, 32'(done[1]), 32'h0);
    chk("arst_led", 1, 32'(led[1]), 32'h00);
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    op(1, 0, 16'h0041, 16'h0002);
    wait_done(1);
    chk_str(1, "0043");
    chk("led_lit", 1, 32'(led[1]), 32'h43);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
